// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures execute results, resolves taken control flow into a
// one-cycle fetch redirect and squashes wrong-path beats. Define EXMEM_FWD_EN to enable the bypass outputs.
module ex_mem_stage #(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [15:0] alu_output_data,
  input  logic [15:0] pc_nxt_p1,
  input  logic        branch_idix_p1,
  input  logic        jmp_idix_p1,
  input  logic        jmp_displacement_idix_p1,
  input  logic [2:0]  dest_reg_idix_p1,
  input  logic        reg_write_valid_idix_p1,
  input  logic        ldst_valid_idix_p1,
  input  logic        mem_write_idix_p1,
  input  logic [15:0] store_data_p1,
  input  logic        mem_ready,
  output logic        exmem_valid,
  output logic [15:0] exmem_data,
  output logic [15:0] exmem_store_data,
  output logic [2:0]  exmem_dest_reg,
  output logic        exmem_reg_write,
  output logic        exmem_ldst,
  output logic        exmem_mem_write,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        fwd_valid,
  output logic [2:0]  fwd_reg,
  output logic [15:0] fwd_data
);

  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [2:0] DEPTH3 = 3'(SQUASH_DEPTH);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       accept, capture, taken;

  assign ex_ready = ~exmem_valid | mem_ready | (state == SQUASH);
  assign accept   = ex_valid & ex_ready;
  // In SQUASH an accepted beat is consumed but never reaches the register.
  assign capture  = accept & (state == RUN);
  assign taken    = (branch_idix_p1 & alu_output_data[0]) | jmp_idix_p1 | jmp_displacement_idix_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (capture && taken && (SQUASH_DEPTH > 0)) begin
          state_nxt = SQUASH;
          cnt_nxt   = DEPTH3;
        end
      end
      SQUASH: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt <= 3'd1) begin
          state_nxt = RUN;
          cnt_nxt   = 3'd0;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      exmem_valid      <= 1'b0;
      exmem_data       <= '0;
      exmem_store_data <= '0;
      exmem_dest_reg   <= '0;
      exmem_reg_write  <= 1'b0;
      exmem_ldst       <= 1'b0;
      exmem_mem_write  <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
    end else begin
      redirect_valid <= capture & taken;
      if (capture && taken) redirect_pc <= pc_nxt_p1;
      if (capture) begin
        exmem_valid      <= 1'b1;
        exmem_data       <= alu_output_data;
        exmem_store_data <= store_data_p1;
        exmem_dest_reg   <= dest_reg_idix_p1;
        exmem_reg_write  <= reg_write_valid_idix_p1 & ~branch_idix_p1;
        exmem_ldst       <= ldst_valid_idix_p1;
        exmem_mem_write  <= mem_write_idix_p1;
      end else if (exmem_valid && mem_ready) begin
        exmem_valid <= 1'b0;
      end
    end
  end

`ifdef EXMEM_FWD_EN
  assign fwd_valid = exmem_valid & exmem_reg_write & ~exmem_ldst;
  assign fwd_reg   = exmem_dest_reg;
  assign fwd_data  = exmem_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = 3'd0;
  assign fwd_data  = 16'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed bench for ex_mem_stage against a cycle-level behavioural model.
module tb_ex_mem_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [15:0] alu_output_data, pc_nxt_p1, store_data_p1;
  logic        branch_idix_p1, jmp_idix_p1, jmp_displacement_idix_p1;
  logic [2:0]  dest_reg_idix_p1;
  logic        reg_write_valid_idix_p1, ldst_valid_idix_p1, mem_write_idix_p1;
  logic        mem_ready;
  logic        exmem_valid, exmem_reg_write, exmem_ldst, exmem_mem_write;
  logic [15:0] exmem_data, exmem_store_data;
  logic [2:0]  exmem_dest_reg;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        fwd_valid;
  logic [2:0]  fwd_reg;
  logic [15:0] fwd_data;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  bit          m_valid, m_rw, m_ldst, m_mw, m_redir;
  logic [15:0] m_data, m_sdata, m_rpc;
  logic [2:0]  m_dest;
  int          m_drop_left;

  always #5 clk = ~clk;

  ex_mem_stage #(.SQUASH_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_output_data(alu_output_data), .pc_nxt_p1(pc_nxt_p1),
    .branch_idix_p1(branch_idix_p1), .jmp_idix_p1(jmp_idix_p1),
    .jmp_displacement_idix_p1(jmp_displacement_idix_p1),
    .dest_reg_idix_p1(dest_reg_idix_p1), .reg_write_valid_idix_p1(reg_write_valid_idix_p1),
    .ldst_valid_idix_p1(ldst_valid_idix_p1), .mem_write_idix_p1(mem_write_idix_p1),
    .store_data_p1(store_data_p1), .mem_ready(mem_ready),
    .exmem_valid(exmem_valid), .exmem_data(exmem_data), .exmem_store_data(exmem_store_data),
    .exmem_dest_reg(exmem_dest_reg), .exmem_reg_write(exmem_reg_write),
    .exmem_ldst(exmem_ldst), .exmem_mem_write(exmem_mem_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !m_valid || mem_ready || (m_drop_left > 0);
  endfunction

  task automatic check_outputs();
    bit fv;
    chk("exmem_valid", exmem_valid, m_valid);
    chk("redirect_valid", redirect_valid, m_redir);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("exmem_data", exmem_data, m_data);
    chk("exmem_store_data", exmem_store_data, m_sdata);
    chk("exmem_dest_reg", exmem_dest_reg, m_dest);
    chk("exmem_reg_write", exmem_reg_write, m_rw);
    chk("exmem_ldst", exmem_ldst, m_ldst);
    chk("exmem_mem_write", exmem_mem_write, m_mw);
`ifdef EXMEM_FWD_EN
    fv = m_valid && m_rw && !m_ldst;
    chk("fwd_valid", fwd_valid, fv);
    chk("fwd_reg", fwd_reg, m_dest);
    chk("fwd_data", fwd_data, m_data);
`else
    fv = 1'b0;
    chk("fwd_valid", fwd_valid, fv);
    chk("fwd_reg", fwd_reg, 3'd0);
    chk("fwd_data", fwd_data, 16'd0);
`endif
  endtask

  // One clock: check ready with settled inputs, advance model, then check registered outputs.
  task automatic step();
    bit rdy, dropping, acc, tk;
    #1;
    rdy = exp_ready();
    chk("ex_ready", ex_ready, rdy);
    dropping = (m_drop_left > 0);
    acc = ex_valid && rdy && !dropping;
    tk  = (branch_idix_p1 && alu_output_data[0]) || jmp_idix_p1 || jmp_displacement_idix_p1;
    @(posedge clk);
    if (!rst) begin
      m_valid = 0; m_rw = 0; m_ldst = 0; m_mw = 0; m_redir = 0;
      m_data = 0; m_sdata = 0; m_rpc = 0; m_dest = 0; m_drop_left = 0;
    end else begin
      if (dropping) m_drop_left--;
      m_redir = acc && tk;
      if (acc) begin
        m_valid = 1;
        m_data  = alu_output_data;
        m_sdata = store_data_p1;
        m_dest  = dest_reg_idix_p1;
        m_rw    = reg_write_valid_idix_p1 && !branch_idix_p1;
        m_ldst  = ldst_valid_idix_p1;
        m_mw    = mem_write_idix_p1;
        if (tk) begin
          m_rpc = pc_nxt_p1;
          m_drop_left = DEPTH;
        end
      end else if (m_valid && mem_ready) begin
        m_valid = 0;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] pc,
                       input bit br, input bit jr, input bit jd, input logic [2:0] d,
                       input bit rw, input bit mr);
    ex_valid = v; alu_output_data = a; pc_nxt_p1 = pc;
    branch_idix_p1 = br; jmp_idix_p1 = jr; jmp_displacement_idix_p1 = jd;
    dest_reg_idix_p1 = d; reg_write_valid_idix_p1 = rw;
    ldst_valid_idix_p1 = 1'b0; mem_write_idix_p1 = 1'b0;
    store_data_p1 = 16'($urandom); mem_ready = mr;
  endtask

  initial begin
    m_valid = 0; m_rw = 0; m_ldst = 0; m_mw = 0; m_redir = 0;
    m_data = 0; m_sdata = 0; m_rpc = 0; m_dest = 0; m_drop_left = 0;
    rst = 1'b0;
    drive(0, 16'h0, 16'h0, 0, 0, 0, 3'd0, 0, 1);
    @(posedge clk);
    #1;

    // Reset
    step(); step();
    rst = 1'b1;
    chk("reset_exmem_valid", exmem_valid, 1'b0);
    chk("reset_redirect", redirect_valid, 1'b0);
    #1;
    chk("reset_ex_ready", ex_ready, 1'b1);

    // ADD pass-through
    drive(1, 16'h1234, 16'h0, 0, 0, 0, 3'd3, 1, 1);
    step();
    chk("add_data", exmem_data, 16'h1234);
    chk("add_dest", exmem_dest_reg, 3'd3);
    chk("add_valid", exmem_valid, 1'b1);

    // Backpressure for 4 cycles, then release with a new beat
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'hBEEF, 16'h0, 0, 0, 0, 3'd5, 1, 0);
      step();
      chk("bp_hold_data", exmem_data, 16'h1234);
      chk("bp_ex_ready", ex_ready, 1'b0);
    end
    drive(1, 16'h5678, 16'h0, 0, 0, 0, 3'd6, 1, 1);
    step();
    chk("bp_release_data", exmem_data, 16'h5678);

    // Taken BEQZ
    drive(1, 16'h0001, 16'h0040, 1, 0, 0, 3'd2, 1, 1);
    step();
    chk("beqz_redirect", redirect_valid, 1'b1);
    chk("beqz_pc", redirect_pc, 16'h0040);
    chk("beqz_no_rw", exmem_reg_write, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 16'hDEAD, 16'h0, 0, 1, 0, 3'd1, 1, 0);
      step();
      chk("squash_drop", exmem_data, 16'h0001);
      chk("squash_no_redirect", redirect_valid, 1'b0);
    end
    drive(1, 16'h0A0A, 16'h0, 0, 0, 0, 3'd4, 1, 1);
    step();
    chk("post_squash_capture", exmem_data, 16'h0A0A);

    // Not-taken BNEZ, next beat captured
    drive(1, 16'h0002, 16'h0080, 1, 0, 0, 3'd1, 1, 1);
    step();
    chk("bnez_no_redirect", redirect_valid, 1'b0);
    drive(1, 16'h3333, 16'h0, 0, 0, 0, 3'd7, 1, 1);
    step();
    chk("bnez_next_capture", exmem_data, 16'h3333);

    // JAL then reset inside the squash window
    drive(1, 16'h0010, 16'h0100, 0, 0, 1, 3'd7, 1, 1);
    step();
    chk("jal_redirect", redirect_valid, 1'b1);
    rst = 1'b0;
    drive(1, 16'h4444, 16'h0, 0, 0, 0, 3'd1, 1, 1);
    step();
    rst = 1'b1;
    chk("jal_reset_redirect", redirect_valid, 1'b0);
    drive(1, 16'h5555, 16'h0, 0, 0, 0, 3'd2, 1, 1);
    step();
    chk("after_reset_capture", exmem_data, 16'h5555);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      sel = $urandom_range(0, 9);
      ex_valid = ($urandom_range(0, 9) < 7);
      alu_output_data = 16'($urandom);
      pc_nxt_p1 = 16'($urandom);
      branch_idix_p1 = (sel == 0) || (sel == 1);
      jmp_idix_p1 = (sel == 2);
      jmp_displacement_idix_p1 = (sel == 3);
      dest_reg_idix_p1 = 3'($urandom);
      reg_write_valid_idix_p1 = 1'($urandom);
      ldst_valid_idix_p1 = 1'($urandom);
      mem_write_idix_p1 = 1'($urandom);
      store_data_p1 = 16'($urandom);
      mem_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

- EX/MEM pipeline register; sits directly downstream of the execute ALU.
- Captures the ALU result, destination register and memory-control sideband for each executed instruction.
- Resolves branches and jumps into a single-cycle redirect to fetch, then squashes wrong-path instructions still arriving from decode.
- Presents a valid/ready handshake both upstream (execute) and downstream (memory stage).

## Interface
Parameters:
- SQUASH_DEPTH, 2, number of cycles after a redirect during which incoming execute beats are dropped (0..7).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_ready  out  1  stage can accept this cycle.
- alu_output_data  in  16  ALU result; bit 0 is the branch condition for branches.
- pc_nxt_p1  in  16  branch/jump target from the ALU adder.
- branch_idix_p1  in  1  conditional branch (BEQZ/BNEZ/BLTZ/BGEZ).
- jmp_idix_p1  in  1  register jump (JR/JALR).
- jmp_displacement_idix_p1  in  1  displacement jump (J/JAL).
- dest_reg_idix_p1  in  3  destination register.
- reg_write_valid_idix_p1  in  1  instruction writes the register file.
- ldst_valid_idix_p1  in  1  load or store; alu_output_data is the address.
- mem_write_idix_p1  in  1  store (qualifies ldst).
- store_data_p1  in  16  rt value for stores.
- mem_ready  in  1  memory stage accepts this cycle.
- exmem_valid  out  1  output register full.
- exmem_data, exmem_store_data  out  16 each  captured result / store data.
- exmem_dest_reg  out  3.
- exmem_reg_write, exmem_ldst, exmem_mem_write  out  1 each.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  16  redirect target.
- fwd_valid  out  1, fwd_reg  out  3, fwd_data  out  16  bypass to execute operand muxes.

## Operation
- Accept rule: accept = ex_valid & ex_ready; ex_ready = ~exmem_valid | mem_ready | (state == SQUASH).
- RUN: on accept, load all exmem_* from the inputs and set exmem_valid = 1.
- Drain: when exmem_valid & mem_ready and there is no accept, clear exmem_valid.
- Simultaneous drain and accept: the new instruction replaces the old one; exmem_valid stays 1.
- Redirect condition: taken = (branch_idix_p1 & alu_output_data[0]) | jmp_idix_p1 | jmp_displacement_idix_p1.
  - On accept with taken, register redirect_valid = 1 and redirect_pc = pc_nxt_p1.
  - Branches force exmem_reg_write = 0 regardless of input.
- State machine, states RUN and SQUASH:
  - RUN -> SQUASH on accept with taken when SQUASH_DEPTH > 0; load the 3-bit counter with SQUASH_DEPTH.
  - In SQUASH, every ex_valid beat is consumed and dropped; the output register is untouched and still drains normally.
  - The counter decrements each cycle; SQUASH -> RUN in the cycle the counter reaches 0.
  - SQUASH_DEPTH = 0: the FSM never leaves RUN.
- Taken control flow seen while in SQUASH is dropped; it generates no redirect.

## Timing
- Capture latency: inputs sampled at the accept edge appear on exmem_* in the following cycle.
- redirect_valid is high for exactly one cycle, the cycle after the accept edge, independent of mem_ready.
- Squash window covers the SQUASH_DEPTH cycles that follow the redirect cycle's edge. The first dropped beat is the one presented in the cycle redirect_valid is high.
- Backpressure: with exmem_valid = 1 and mem_ready = 0 in RUN, ex_ready = 0 and the register holds all fields stable.
- Reset, including mid-squash:
  - All outputs become 0 and ex_ready becomes 1 in the first cycle after the reset edge.
  - state = RUN, counter = 0.
  - A pending redirect is discarded.

## Configuration
- EXMEM_FWD_EN defined:
  - fwd_valid = exmem_valid & exmem_reg_write & ~exmem_ldst.
  - fwd_reg = exmem_dest_reg, fwd_data = exmem_data.
  - All bypass outputs are combinational from the output register.
- EXMEM_FWD_EN undefined:
  - fwd_valid, fwd_reg and fwd_data are tied to 0.
  - Decode interlocks on RAW hazards.

## Test plan
- Reset: rst = 0 for 2 cycles, then rst = 1 -> all outputs 0, ex_ready = 1.
- ADD pass-through: ex_valid = 1, alu_output_data = 16'h1234, dest = 3, reg_write = 1, mem_ready = 1 -> next cycle exmem_valid = 1, exmem_data = 16'h1234, exmem_dest_reg = 3; with EXMEM_FWD_EN, fwd_valid = 1 and fwd_data = 16'h1234.
- Backpressure: hold mem_ready = 0 with register full -> ex_ready = 0 and exmem_data stable for 4 cycles; raise mem_ready with ex_valid = 1 -> new data loads on that edge.
- Taken BEQZ: branch = 1, alu_output_data = 16'h0001, pc_nxt_p1 = 16'h0040 -> redirect_valid = 1 for one cycle, redirect_pc = 16'h0040, exmem_reg_write = 0; the next 2 ex_valid beats are dropped.
- Not-taken BNEZ: alu_output_data[0] = 0 -> no redirect and the next beat is captured.
- JAL, then rst = 0 during the squash window -> counter cleared; after reset the first ex_valid beat is captured.
